seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Iterative restoring divider; the inverse of the registered multiply-add datapath (r = a*b + c).
//  Takes an unsigned NUM_W-bit dividend and a DEN_W-bit divisor.
//  Returns quotient and remainder, one quotient bit per clock.
//  Valid/ready handshakes on both sides, so it drops into the same logic-only arithmetic pipelines.
//  Round-trip check: feeding num = a*b + c and den = b gives quo = a and rem = c when c < b.
// PARAMETERS
//  NUM_W  8  dividend and quotient width (>= 2)
//  DEN_W  4  divisor and remainder width (1..NUM_W)
// PORTS
//  clk        in   1      single clock, all logic on posedge
//  rst_n      in   1      synchronous, active-low reset
//  in_valid   in   1      num/den valid
//  in_ready   out  1      divider can accept an operand pair
//  num        in   NUM_W  dividend, unsigned
//  den        in   DEN_W  divisor, unsigned
//  out_valid  out  1      quo/rem/div_zero valid
//  out_ready  in   1      downstream accepts the result
//  quo        out  NUM_W  quotient
//  rem        out  DEN_W  remainder
//  div_zero   out  1      den was 0 for this result
// BEHAVIOUR
//  Reset (rst_n=0 at a posedge):
//   - state=IDLE; in_ready=1; out_valid=0; quo=0; rem=0; div_zero=0; iteration counter=0.
//  FSM states: IDLE, CALC, DONE.
//   - IDLE: in_ready=1.
//     - in_valid=1 and den!=0: latch operands; partial remainder (DEN_W+1 bits)=0; cnt=NUM_W; go CALC.
//     - in_valid=1 and den==0: go DONE with quo=all ones, rem=0, div_zero=1.
//   - CALC: in_ready=0. Each clock runs one restoring step, MSB of dividend first:
//     - shift the remainder left and bring in the next dividend bit;
//     - if the shifted remainder >= den: subtract den and shift in quotient bit 1, else shift in 0;
//     - cnt decrements; on the step where cnt reaches 0, go DONE.
//   - DONE: out_valid=1; quo/rem/div_zero held stable while out_valid=1 and out_ready=0.
//     - on out_valid&out_ready: go IDLE, out_valid=0.
//  Latency:
//   - non-zero divisor: out_valid first seen high NUM_W clocks after the accepting edge (8 for defaults).
//   - den==0: 1 clock after the accepting edge.
//  Throughput: one division per NUM_W+2 clocks at best.
//   - in_ready is high only in IDLE, so there is no accept in the same cycle as result hand-off.
//  Arithmetic:
//   - unsigned only; the remainder is always < den, so it fits DEN_W bits.
//   - quo is exact for every num, including den=1 (quo=num, rem=0).
//  Boundary and corner cases:
//   - in_valid with in_ready=0 is ignored; the upstream must hold its data.
//   - num/den changing during CALC have no effect (operands are latched).
//   - rst_n low mid-CALC or in DONE: abort, apply the reset values above; the result is lost and no out_valid pulse appears.
//   - out_ready high while out_valid=0 has no effect.
// TESTING
//  1 num=200, den=7 -> after 8 clks out_valid=1, quo=28, rem=4, div_zero=0.
//  2 num=145, den=13 (11*13+2) -> quo=11, rem=2. num=255, den=1 -> quo=255, rem=0.
//  3 num=5, den=9 -> quo=0, rem=5. num=0, den=15 -> quo=0, rem=0.
//  4 den=0, num=77 -> out_valid 1 clk after accept; quo=8'hFF, rem=0, div_zero=1.
//  5 out_ready low for 5 clks in DONE -> outputs stable, in_ready=0; the next accept happens only after the hand-off.
//  6 rst_n low at CALC step 3 -> next clk: in_ready=1, out_valid=0, quo=0. A fresh 100/3 then gives quo=33, rem=1.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider producing one quotient bit per clock with valid/ready handshakes
module seq_divider #(
  parameter int NUM_W = 8,
  parameter int DEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NUM_W-1:0] quo,
  output logic [DEN_W-1:0] rem,
  output logic             div_zero
);
  localparam int CW = $clog2(NUM_W + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]       state;
  logic [NUM_W-1:0] num_q;
  logic [DEN_W-1:0] den_q;
  logic [DEN_W-1:0] part;
  logic [DEN_W:0]   shifted;
  logic [DEN_W-1:0] diff;
  logic [DEN_W-1:0] part_nxt;
  logic [NUM_W-1:0] num_nxt;
  logic             ge;
  logic [CW-1:0]    cnt;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  // One restoring step: the dividend register shifts out its MSB and fills with quotient bits
  always_comb begin
    shifted  = {part, num_q[NUM_W-1]};
    ge       = shifted >= {1'b0, den_q};
    diff     = shifted[DEN_W-1:0] - den_q;
    part_nxt = ge ? diff : shifted[DEN_W-1:0];
    num_nxt  = {num_q[NUM_W-2:0], ge};
  end
  // Handshake FSM; results are only published on the final step so outputs stay clean during CALC
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      num_q    <= '0;
      den_q    <= '0;
      part     <= '0;
      cnt      <= '0;
      quo      <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
    end else if (state == IDLE) begin
      if (in_valid && den != '0) begin
        num_q    <= num;
        den_q    <= den;
        part     <= '0;
        cnt      <= CW'(NUM_W);
        div_zero <= 1'b0;
        state    <= CALC;
      end else if (in_valid) begin
        quo      <= '1;
        rem      <= '0;
        div_zero <= 1'b1;
        state    <= DONE;
      end
    end else if (state == CALC) begin
      part  <= part_nxt;
      num_q <= num_nxt;
      cnt   <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        quo   <= num_nxt;
        rem   <= part_nxt;
        state <= DONE;
      end
    end else if (state == DONE) begin
      if (out_ready) state <= IDLE;
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random divisions checked against plain integer division
module tb_seq_divider;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       in_valid = 0;
  logic       in_ready;
  logic [7:0] num = 0;
  logic [3:0] den = 0;
  logic       out_valid;
  logic       out_ready = 0;
  logic [7:0] quo;
  logic [3:0] rem;
  logic       div_zero;
  int errors = 0;
  int checks = 0;

  seq_divider #(.NUM_W(8), .DEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .num(num), .den(den), .out_valid(out_valid), .out_ready(out_ready),
    .quo(quo), .rem(rem), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input logic [7:0] n, input logic [3:0] d, input int hold);
    int k;
    logic [7:0] eq;
    logic [3:0] er;
    eq = (d == 0) ? 8'hFF : 8'(n / d);
    er = (d == 0) ? 4'd0 : 4'(n % d);
    k = 0;
    while (!in_ready && k < 50) begin tick(); k++; end
    check("ready", {31'd0, in_ready}, 1);
    in_valid = 1; num = n; den = d;
    tick();
    num = 8'($urandom); den = 4'($urandom);
    k = 0;
    while (!out_valid && k < 50) begin tick(); k++; end
    in_valid = 0;
    if (d != 0) check("latency", k, 8);
    else check("latency_dz", {31'd0, k <= 1}, 1);
    check("quo", {24'd0, quo}, {24'd0, eq});
    check("rem", {28'd0, rem}, {28'd0, er});
    check("div_zero", {31'd0, div_zero}, {31'd0, d == 0});
    check("busy", {31'd0, in_ready}, 0);
    repeat (hold) begin
      tick();
      check("hold_valid", {31'd0, out_valid}, 1);
      check("hold_quo", {24'd0, quo}, {24'd0, eq});
      check("hold_rem", {28'd0, rem}, {28'd0, er});
      check("hold_ready", {31'd0, in_ready}, 0);
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    check("handoff", {31'd0, out_valid}, 0);
  endtask

  initial begin
    repeat (2) tick();
    check("rst_in_ready", {31'd0, in_ready}, 1);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_quo", {24'd0, quo}, 0);
    check("rst_rem", {28'd0, rem}, 0);
    check("rst_div_zero", {31'd0, div_zero}, 0);
    rst_n = 1;
    out_ready = 1;
    repeat (2) tick();
    out_ready = 0;
    check("idle_out_ready", {31'd0, out_valid}, 0);
    run_div(200, 7, 0);
    run_div(145, 13, 1);
    run_div(255, 1, 0);
    run_div(5, 9, 0);
    run_div(0, 15, 0);
    run_div(77, 0, 0);
    run_div(123, 4, 5);
    in_valid = 1; num = 200; den = 7;
    tick();
    in_valid = 0;
    repeat (3) tick();
    rst_n = 0;
    tick();
    check("abort_in_ready", {31'd0, in_ready}, 1);
    check("abort_out_valid", {31'd0, out_valid}, 0);
    check("abort_quo", {24'd0, quo}, 0);
    rst_n = 1;
    repeat (10) begin
      tick();
      check("abort_no_pulse", {31'd0, out_valid}, 0);
    end
    run_div(100, 3, 0);
    for (int i = 0; i < 40; i++)
      run_div(8'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
